// File: rtl/systolic_ctrl.sv
// systolic_ctrl: weight-load / settle / stream / drain sequencer for one PE array.
// Optional WCLR_EN adds Clr_W, turning the load sweep into a weight-clear sweep.
module systolic_ctrl #(
    parameter int ROWS       = 8,
    parameter int BIT_ROW_ID = 4,
    parameter int BIT_VALID  = 8,
    parameter int BIT_VEC    = 9,
    parameter int DRAIN_CYC  = 17
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
`ifdef WCLR_EN
    input  logic                  Clr_W,
`endif
    input  logic                  Keep_W,
    input  logic [BIT_VEC-1:0]    Num_Vec,
    output logic                  Busy,
    output logic                  Done,
    output logic                  W_Rd,
    output logic [BIT_ROW_ID-1:0] W_Addr,
    output logic                  EN_W,
    output logic [BIT_ROW_ID-1:0] EN_ID,
    output logic                  I_Rd,
    output logic [BIT_VEC-1:0]    I_Addr,
    output logic [BIT_VEC-1:0]    Addr_P,
    output logic [BIT_VALID-1:0]  Valid_P
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    // No row matches this tag, so idle cycles never disturb resident weights.
    localparam logic [BIT_ROW_ID-1:0] IDLE_TAG = BIT_ROW_ID'(ROWS);
    localparam logic [BIT_VEC-1:0] LOAD_LAST   = BIT_VEC'(ROWS - 1);
    localparam logic [BIT_VEC-1:0] SETTLE_LAST = BIT_VEC'(ROWS);
    // DRAIN state spans DRAIN_CYC-1 cycles; Done lands on the IDLE-entry cycle,
    // DRAIN_CYC cycles after the last input issue.
    localparam logic [BIT_VEC-1:0] DRAIN_LAST  = BIT_VEC'(DRAIN_CYC - 2);

    state_t             state;
    state_t             state_nxt;
    logic [BIT_VEC-1:0] cnt;
    logic [BIT_VEC-1:0] cnt_nxt;
    logic [BIT_VEC-1:0] cnt_inc;
    logic [BIT_VEC-1:0] num_q;
    logic [BIT_VEC-1:0] num_nxt;
    logic               clr_q;
    logic               clr_nxt;
    logic               done_nxt;
    logic               go_load;
    logic               start_clr;
    logic               in_load;

`ifdef WCLR_EN
    assign start_clr = Clr_W;
`else
    assign start_clr = 1'b0;
`endif

    // Clear has priority over reuse of resident weights.
    assign go_load = start_clr | ~Keep_W;

    // Counter saturates at all-ones so it can never wrap inside a command.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + BIT_VEC'(1);

    assign in_load = (state == S_LOAD);
    assign Busy    = (state != S_IDLE);
    assign W_Rd    = in_load & ~clr_q;
    assign W_Addr  = in_load ? cnt[BIT_ROW_ID-1:0] : '0;
    assign I_Rd    = (state == S_STREAM);
    assign I_Addr  = I_Rd ? cnt : '0;

    // State, counter, latched command and one-cycle-delayed array tags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            num_q   <= '0;
            clr_q   <= 1'b0;
            Done    <= 1'b0;
            EN_W    <= 1'b0;
            EN_ID   <= IDLE_TAG;
            Addr_P  <= '0;
            Valid_P <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            num_q   <= num_nxt;
            clr_q   <= clr_nxt;
            Done    <= done_nxt;
            EN_W    <= W_Rd;
            EN_ID   <= in_load ? W_Addr : IDLE_TAG;
            Addr_P  <= I_Rd ? I_Addr : '0;
            Valid_P <= {BIT_VALID{I_Rd}};
        end
    end

    // Next-state and counter sequencing for the command flow.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        num_nxt   = num_q;
        clr_nxt   = clr_q;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (Start) begin
                    num_nxt = Num_Vec;
                    clr_nxt = start_clr;
                    if (go_load)
                        state_nxt = S_LOAD;
                    else if (Num_Vec == '0)
                        state_nxt = S_DRAIN;
                    else
                        state_nxt = S_STREAM;
                end
            end
            S_LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = (num_q != '0) ? S_STREAM : S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_STREAM: begin
                if (cnt == num_q - BIT_VEC'(1)) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            S_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: table-driven command runs with a per-cycle expected-output
// queue, plus hand sequences for idle, reset-mid-load and restart.
module tb_systolic_ctrl;

    logic       CLK;
    logic       RST;
    logic       Start;
    logic       Keep_W;
    logic [8:0] Num_Vec;
    logic       Busy;
    logic       Done;
    logic       W_Rd;
    logic [3:0] W_Addr;
    logic       EN_W;
    logic [3:0] EN_ID;
    logic       I_Rd;
    logic [8:0] I_Addr;
    logic [8:0] Addr_P;
    logic [7:0] Valid_P;
`ifdef WCLR_EN
    logic       Clr_W;
`endif

    systolic_ctrl dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
`ifdef WCLR_EN
        .Clr_W   (Clr_W),
`endif
        .Keep_W  (Keep_W),
        .Num_Vec (Num_Vec),
        .Busy    (Busy),
        .Done    (Done),
        .W_Rd    (W_Rd),
        .W_Addr  (W_Addr),
        .EN_W    (EN_W),
        .EN_ID   (EN_ID),
        .I_Rd    (I_Rd),
        .I_Addr  (I_Addr),
        .Addr_P  (Addr_P),
        .Valid_P (Valid_P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       w_rd;
        logic [3:0] w_addr;
        logic       en_w;
        logic [3:0] en_id;
        logic       i_rd;
        logic [8:0] i_addr;
        logic [8:0] addr_p;
        logic [7:0] valid_p;
    } obs_t;

    typedef struct {
        logic clr;
        logic keep;
        int   num;
        int   spur;
        int   done_cyc;
    } cmd_t;

    int   checks;
    int   errors;
    obs_t exp_q[$];
    obs_t idle_obs;

    function automatic obs_t sample();
        obs_t o;
        o.busy    = Busy;
        o.done    = Done;
        o.w_rd    = W_Rd;
        o.w_addr  = W_Addr;
        o.en_w    = EN_W;
        o.en_id   = EN_ID;
        o.i_rd    = I_Rd;
        o.i_addr  = I_Addr;
        o.addr_p  = Addr_P;
        o.valid_p = Valid_P;
        return o;
    endfunction

    task automatic check_pop(input string name);
        obs_t e;
        obs_t a;
        a = sample();
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s got %h want %h", name, a, e);
            end
        end
    endtask

    task automatic drive_idle();
        Start   = 1'b0;
        Keep_W  = 1'b0;
        Num_Vec = '0;
`ifdef WCLR_EN
        Clr_W   = 1'b0;
`endif
    endtask

    task automatic run_cmd(input cmd_t c, input int id);
        obs_t e;
        logic ld;
        int   s;
        ld = c.clr | ~c.keep;
        s  = ld ? 18 : 1;
        for (int k = 0; k <= c.done_cyc + 2; k++) begin
            e        = idle_obs;
            e.busy   = (k >= 1) && (k < c.done_cyc);
            e.done   = (k == c.done_cyc);
            if (ld && !c.clr && k >= 1 && k <= 8) begin
                e.w_rd   = 1'b1;
                e.w_addr = 4'(k - 1);
            end
            if (ld && k >= 2 && k <= 9) begin
                e.en_w  = ~c.clr;
                e.en_id = 4'(k - 2);
            end
            if (k >= s && k < s + c.num) begin
                e.i_rd   = 1'b1;
                e.i_addr = 9'(k - s);
            end
            if (k >= s + 1 && k <= s + c.num) begin
                e.addr_p  = 9'(k - s - 1);
                e.valid_p = 8'hFF;
            end
            exp_q.push_back(e);
        end
        for (int k = 0; k <= c.done_cyc + 2; k++) begin
            Start   = (k == 0) || (c.spur != 0 && k == c.spur);
            Keep_W  = (k == 0) ? c.keep : ~c.keep;
            Num_Vec = (k == 0) ? 9'(c.num) : 9'(c.num + 3);
`ifdef WCLR_EN
            Clr_W   = (k == 0) ? c.clr : 1'b0;
`endif
            @(negedge CLK);
            check_pop($sformatf("cmd%0d_cyc%0d", id, k));
            @(posedge CLK);
            #1;
        end
        drive_idle();
    endtask

    cmd_t tbl[7];
    int   nt;

    initial begin
        checks   = 0;
        errors   = 0;
        idle_obs = '0;
        idle_obs.en_id = 4'd8;

        tbl[0] = '{clr: 1'b0, keep: 1'b0, num: 4,   spur: 0, done_cyc: 38};
        tbl[1] = '{clr: 1'b0, keep: 1'b1, num: 1,   spur: 0, done_cyc: 18};
        tbl[2] = '{clr: 1'b0, keep: 1'b0, num: 0,   spur: 0, done_cyc: 34};
        tbl[3] = '{clr: 1'b0, keep: 1'b1, num: 3,   spur: 2, done_cyc: 20};
        tbl[4] = '{clr: 1'b0, keep: 1'b1, num: 0,   spur: 0, done_cyc: 17};
        tbl[5] = '{clr: 1'b0, keep: 1'b1, num: 511, spur: 0, done_cyc: 528};
        tbl[6] = '{clr: 1'b1, keep: 1'b1, num: 2,   spur: 0, done_cyc: 36};
`ifdef WCLR_EN
        nt = 7;
`else
        nt = 6;
`endif

        RST = 1'b1;
        drive_idle();
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        exp_q.push_back(idle_obs);
        check_pop("reset_state");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 20; i++) exp_q.push_back(idle_obs);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check_pop($sformatf("idle_%0d", i));
            @(posedge CLK);
            #1;
        end

        for (int i = 0; i < nt; i++) run_cmd(tbl[i], i);

        Start   = 1'b1;
        Keep_W  = 1'b0;
        Num_Vec = 9'd4;
        for (int k = 0; k <= 4; k++) begin
            obs_t e;
            e = idle_obs;
            if (k >= 1) begin
                e.busy   = 1'b1;
                e.w_rd   = 1'b1;
                e.w_addr = 4'(k - 1);
            end
            if (k >= 2) begin
                e.en_w  = 1'b1;
                e.en_id = 4'(k - 2);
            end
            exp_q.push_back(e);
            if (k == 4) RST = 1'b1;
            @(negedge CLK);
            check_pop($sformatf("rstload_cyc%0d", k));
            @(posedge CLK);
            #1;
            drive_idle();
        end
        RST = 1'b0;
        for (int i = 0; i < 40; i++) exp_q.push_back(idle_obs);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            check_pop($sformatf("post_rst_%0d", i));
            @(posedge CLK);
            #1;
        end

        run_cmd(tbl[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
